main_store_serial: RTL and testbench
====================================

MAIN_STORE_SERIAL -- requirements
Module: main_store_serial

Interface
REQ-001 Parameter INSTR_L_BITS, default 10, is the line-address width; the store holds 2**INSTR_L_BITS lines.
REQ-002 Parameter WORD_BITS, default 32, is the bits per store line.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  INSTR_L_BITS  line address from the gated L staticisor output.
REQ-006 ha  input  1  action-beat qualifier; access permitted only while high.
REQ-007 start  input  1  request a one-line access; sampled each cycle.
REQ-008 wr  input  1  write mode for the access; sampled with start.
REQ-009 din  input  1  serial write bit, consumed LSB first during a write access.
REQ-010 dout  output  1  serial read bit, LSB first.
REQ-011 dvalid  output  1  dout carries a store bit this cycle.
REQ-012 busy  output  1  access in progress.
REQ-013 done  output  1  one-cycle pulse, access completed.
REQ-014 bitpos  output  clog2(WORD_BITS)  index of the bit on dout/din this cycle.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and FIN.
REQ-016 In IDLE with start=1 and ha=1, the block SHALL latch a into an internal line register and wr into a mode register, clear the bit counter, and enter SHIFT.
REQ-017 In IDLE, a start with ha=0 SHALL be ignored: no state change, no latch.
REQ-018 start while busy=1 SHALL be ignored; the latched address and mode SHALL hold for the whole access.
REQ-019 Timing: if start is accepted at edge N, bit k SHALL be presented on dout with dvalid=1 and bitpos=k in the cycle after edge N+1+k, for k = 0..WORD_BITS-1.
REQ-020 dout SHALL carry the stored value of bit k of the latched line before any write in the same access (read-before-write), in both modes.
REQ-021 In write mode, din sampled at the edge ending the bitpos=k cycle SHALL be written to bit k of the latched line; in read mode the store SHALL be unchanged (regeneration).
REQ-022 After the bitpos=WORD_BITS-1 cycle the FSM SHALL enter FIN for exactly one cycle with done=1 and dvalid=0, then return to IDLE.
REQ-023 A new start SHALL be accepted no earlier than the IDLE cycle following FIN; minimum repeat period is WORD_BITS+2 cycles.
REQ-024 The bit counter SHALL NOT wrap; reaching WORD_BITS-1 always ends SHIFT.
REQ-025 If ha falls to 0 during SHIFT, the FSM SHALL go to IDLE at the next edge without done; bits already written SHALL remain; later bits SHALL be untouched.
REQ-026 busy SHALL be 1 in SHIFT and FIN, 0 in IDLE.
REQ-027 dvalid SHALL be 1 only in SHIFT; bitpos and dout SHALL be 0 whenever dvalid=0.
REQ-028 When ha falls on the same edge as the last bit (bitpos=WORD_BITS-1), the abort SHALL take priority: that bit's write occurs, FIN is skipped, no done.

Reset
REQ-029 At rst=1 on a rising edge the FSM SHALL go to IDLE, and busy, done, dvalid, dout and bitpos SHALL be 0 from the next cycle.
REQ-030 rst SHALL take priority over start and ha; reset mid-access SHALL abort with no done; bits written before that edge SHALL remain.
REQ-031 Store contents SHALL be all zero at power-up and SHALL NOT be altered by rst.

Verification
REQ-032 Write/read-back: write 0x8000_0001 to line 5, read line 5 -> dout 1,0x30,1 over bitpos 0..31; done exactly 33 cycles after each start edge.
REQ-033 Read-before-write: line 3 = 0xFFFF_FFFF; write 0x0 -> dout all ones during the write; a later read returns 0x0.
REQ-034 Gating: start=1 with ha=0 in IDLE -> busy stays 0, no dvalid; start during SHIFT -> latched address unchanged.
REQ-035 Abort: ha drops after bitpos=7 while writing 0xFFFF_FFFF over 0x0 on line 9 -> no done; line 9 reads 0x0000_00FF.
REQ-036 Reset mid-access: rst at bitpos=10 -> next cycle busy=0, dvalid=0, done=0; line contents before the edge preserved.
REQ-037 Boundaries: line 0 and line 2**INSTR_L_BITS-1 (1023) write/read 0xA5A5_A5A5 independently; back-to-back accesses accepted with a 34-cycle start period.

Source files
------------

// File: rtl/main_store_serial.sv
`default_nettype none
// ============================================================================
// main_store_serial : bit-serial main store, one line per access, LSB first,
//                     read-before-write with regeneration in read mode.
// Revision 1.0
// ============================================================================
module main_store_serial #(
  parameter int INSTR_L_BITS = 10,
  parameter int WORD_BITS    = 32,
  localparam int POS_BITS    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INSTR_L_BITS-1:0] a,
  input  logic                    ha,
  input  logic                    start,
  input  logic                    wr,
  input  logic                    din,
  output logic                    dout,
  output logic                    dvalid,
  output logic                    busy,
  output logic                    done,
  output logic [POS_BITS-1:0]     bitpos
);

  localparam int                  LINES    = 2 ** INSTR_L_BITS;
  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [INSTR_L_BITS-1:0] line_q, line_d;
  logic                    wr_q, wr_d;
  logic                    dout_q, dout_d;
  logic                    dvalid_q, dvalid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [POS_BITS-1:0]     bitpos_q, bitpos_d;
  logic [POS_BITS-1:0]     pos_next;
  logic                    we;

  logic [WORD_BITS-1:0]    store_q [LINES];

  // The first SHIFT cycle only fetches bit 0; afterwards bitpos doubles as
  // the bit counter and the displayed bit is the one written back.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    wr_d     = wr_q;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    done_d   = 1'b0;
    bitpos_d = '0;
    we       = 1'b0;
    pos_next = dvalid_q ? bitpos_q + POS_BITS'(1) : '0;

    case (state_q)
      IDLE: begin
        if (start && ha) begin
          state_d = SHIFT;
          line_d  = a;
          wr_d    = wr;
        end
      end
      SHIFT: begin
        we = dvalid_q && wr_q;
        if (!ha) begin
          state_d = IDLE;
        end else if (dvalid_q && (bitpos_q == LAST_POS)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          dvalid_d = 1'b1;
          bitpos_d = pos_next;
          dout_d   = store_q[line_q][pos_next];
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      line_q   <= '0;
      wr_q     <= 1'b0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bitpos_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      wr_q     <= wr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bitpos_q <= bitpos_d;
    end
  end

  // Store contents survive reset; the bit on display at a reset edge is not written.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      store_q[line_q][bitpos_q] <= din;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign bitpos = bitpos_q;

endmodule
`default_nettype wire

// File: tb/tb_main_store_serial.sv
`default_nettype none
// ============================================================================
// tb_main_store_serial : scoreboard bench for the serial main store.
// Revision 1.0
// ============================================================================
module tb_main_store_serial;

  localparam int LB = 10;
  localparam int WB = 32;

  logic          clk = 1'b0;
  logic          rst, ha, start, wr, din;
  logic [LB-1:0] a;
  logic          dout, dvalid, busy, done;
  logic [4:0]    bitpos;

  main_store_serial #(.INSTR_L_BITS(LB), .WORD_BITS(WB)) dut (
    .clk(clk), .rst(rst), .a(a), .ha(ha), .start(start), .wr(wr), .din(din),
    .dout(dout), .dvalid(dvalid), .busy(busy), .done(done), .bitpos(bitpos)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int   pos;
    logic b;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] model [1024];
  logic [31:0] rd_word;
  logic        exp_done = 1'b0;

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (dvalid) begin
      if (sbq.size() == 0) begin
        check("unexpected_dvalid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("bitpos", 32'(bitpos), 32'(e.pos));
        check("dout", 32'(dout), 32'(e.b));
        rd_word[bitpos] = dout;
      end
    end
    if (done || exp_done) check("done", 32'(done), 32'(exp_done));
  end

  task automatic idle_checks(input string tag);
    @(negedge clk);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_dvalid"}, 32'(dvalid), 32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_dout"},   32'(dout),   32'd0);
    check({tag, "_bitpos"}, 32'(bitpos), 32'd0);
  endtask

  // abort_at / rst_at: bit cycle during which ha is low / rst is high (-1 = none)
  task automatic access(input logic [LB-1:0] line, input logic w, input logic [31:0] data,
                        input int abort_at, input int rst_at);
    int last;
    exp_t x;
    last = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : WB - 1;
    rd_word = '0;
    for (int k = 0; k <= last; k++) begin
      x.pos = k;
      x.b   = model[line][k];
      sbq.push_back(x);
    end
    a = line; wr = w; start = 1'b1; ha = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~line; wr = ~w;
    @(negedge clk);
    check("gap_busy",   32'(busy),   32'd1);
    check("gap_dvalid", 32'(dvalid), 32'd0);
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      #1 din = data[k];
      if (k == abort_at) ha = 1'b0;
      if (k == rst_at) rst = 1'b1;
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      @(posedge clk);
      if (w && k != rst_at) model[line][k] = data[k];
    end
    #1 rst = 1'b0; ha = 1'b1; din = 1'b0; start = 1'b0;
    if (abort_at < 0 && rst_at < 0) begin
      exp_done = 1'b1;
      @(negedge clk);
      check("fin_busy",   32'(busy),   32'd1);
      check("fin_dvalid", 32'(dvalid), 32'd0);
      check("fin_bitpos", 32'(bitpos), 32'd0);
      @(posedge clk);
      #1 exp_done = 1'b0;
    end
    idle_checks("post");
    @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    rst = 1'b1; ha = 1'b0; start = 1'b0; wr = 1'b0; din = 1'b0; a = '0;
    repeat (3) @(posedge clk);
    idle_checks("reset");
    @(posedge clk);
    #1 rst = 1'b0; ha = 1'b1;

    // write/read-back
    access(10'd5, 1'b1, 32'h8000_0001, -1, -1);
    access(10'd5, 1'b0, 32'h0, -1, -1);
    check("rd_line5", rd_word, 32'h8000_0001);
    access(10'd5, 1'b0, 32'h0, -1, -1);
    check("regen_line5", rd_word, 32'h8000_0001);

    // read-before-write
    access(10'd3, 1'b1, 32'hFFFF_FFFF, -1, -1);
    access(10'd3, 1'b1, 32'h0000_0000, -1, -1);
    check("rbw_line3", rd_word, 32'hFFFF_FFFF);
    access(10'd3, 1'b0, 32'h0, -1, -1);
    check("rd_line3", rd_word, 32'h0000_0000);

    // start with ha low is ignored
    start = 1'b1; ha = 1'b0; a = 10'd7;
    repeat (3) idle_checks("gated");
    @(posedge clk);
    #1 start = 1'b0; ha = 1'b1;
    idle_checks("gated_after");

    // ha abort on bit 7
    access(10'd9, 1'b1, 32'h0, -1, -1);
    access(10'd9, 1'b1, 32'hFFFF_FFFF, 7, -1);
    access(10'd9, 1'b0, 32'h0, -1, -1);
    check("abort_line9", rd_word, 32'h0000_00FF);

    // abort on the last bit: that bit still written
    access(10'd11, 1'b1, 32'h0, -1, -1);
    access(10'd11, 1'b1, 32'hFFFF_FFFF, WB - 1, -1);
    access(10'd11, 1'b0, 32'h0, -1, -1);
    check("abort_last", rd_word, 32'hFFFF_FFFF);

    // reset during bit 10
    access(10'd12, 1'b1, 32'h0, -1, -1);
    access(10'd12, 1'b1, 32'hFFFF_FFFF, -1, 10);
    access(10'd12, 1'b0, 32'h0, -1, -1);
    check("rst_line12", rd_word, 32'h0000_03FF);

    // boundary lines, back-to-back
    access(10'd0,    1'b1, 32'hA5A5_A5A5, -1, -1);
    access(10'd1023, 1'b1, 32'h5A5A_5A5A, -1, -1);
    access(10'd0,    1'b0, 32'h0, -1, -1);
    check("rd_line0", rd_word, 32'hA5A5_A5A5);
    access(10'd1023, 1'b0, 32'h0, -1, -1);
    check("rd_line1023_a", rd_word, 32'h5A5A_5A5A);
    access(10'd1023, 1'b1, 32'hA5A5_A5A5, -1, -1);
    access(10'd1023, 1'b0, 32'h0, -1, -1);
    check("rd_line1023_b", rd_word, 32'hA5A5_A5A5);
    access(10'd0,    1'b0, 32'h0, -1, -1);
    check("rd_line0_again", rd_word, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
